// File: rtl/bcd_pkg.sv
// Shared types and defaults for the sum binary-to-BCD converter.
// Counter width helper keeps the top parameterisable.
package bcd_pkg;

  localparam int BCD_IN_W   = 65;
  localparam int BCD_DIGITS = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_t;

  function automatic int cnt_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
// Purely combinational; the 4-bit result drops any carry.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/sum_bcd_converter.sv
// Serial double-dabble converter for the adder sum: IN_W+1 cycles from accepted start to done.
// No backpressure; start is ignored while a conversion runs, bcd_out holds until the next done.
module sum_bcd_converter
  import bcd_pkg::*;
#(
  parameter int IN_W   = BCD_IN_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = cnt_width(IN_W);
  localparam int BCD_W = 4 * DIGITS;

  bcd_state_t        state;
  bcd_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [IN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]  bcd_sr;
  logic [BCD_W-1:0]  bcd_adj;
  logic              load;
  logic              shift_en;
  logic              finish;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_sr[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // cnt==1 means this cycle performs the last of the IN_W shifts
        if (cnt == CNT_W'(1)) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
    end else if (load) begin
      bin_sr <= bin_in;
      bcd_sr <= '0;
      cnt    <= CNT_W'(IN_W);
    end else if (shift_en) begin
      // adjusted digits and remaining binary shift as one register; binary MSB enters digit 0
      {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
      cnt              <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= finish;
      if (load) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (finish) begin
        bcd_out <= bcd_sr;
      end
    end
  end

endmodule

// File: doc/sum_bcd_converter.md
# sum_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the 64-bit adder (`adder4`). It captures the adder's 65-bit unsigned sum on a start pulse. It then runs a shift-and-add-3 (double-dabble) loop, one bit per clock, and presents 20 packed BCD digits with a one-cycle done pulse for the display/readout stage.

## Interface
- `IN_W`, default 65: binary input width; matches the adder sum width.
- `DIGITS`, default 20: BCD digit count. Must satisfy DIGITS ≥ ceil(IN_W·log10 2); 20 covers 2^65−1.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request conversion; sampled only in IDLE.
- `bin_in`, in, IN_W: unsigned binary value (adder `sout`); sampled on the accepted `start` edge.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: single-cycle pulse; `bcd_out` valid and updated.
- `bcd_out`, out, 4·DIGITS: packed BCD, digit 0 (units) in bits [3:0].

## Operation
- FSM states:
  - IDLE: accept start.
  - SHIFT: IN_W iterations.
  - FINISH: load output, pulse done, return to IDLE.
- IDLE with `start`=1:
  - Latch `bin_in` into the shift register.
  - Clear the BCD working register.
  - Load the iteration counter with IN_W.
  - Go to SHIFT.
- SHIFT, each cycle:
  - For every digit ≥ 5, add 3 (4-bit result, no carry out).
  - Shift the {BCD, binary} register left by 1; the binary MSB enters BCD bit 0.
  - Decrement the counter.
  - When the counter reaches 1 on this cycle's shift, go to FINISH.
- FINISH:
  - `bcd_out` ← BCD working register.
  - `done` = 1 for exactly this one cycle.
  - Go to IDLE.
- `start` while not in IDLE is ignored; no queuing.
- `bin_in` changes after acceptance have no effect.
- `bcd_out` holds the last result until the next FINISH. It is never partially updated.
- Every digit of `bcd_out` is always in 0–9.

## Timing
- Reset values:
  - state = IDLE
  - `busy` = 0
  - `done` = 0
  - `bcd_out` = 0
  - internal registers = 0
- Reset asserted mid-conversion:
  - Immediate abort to IDLE.
  - No `done` pulse.
  - `bcd_out` returns to 0.
- Accepting edge E (start=1 in IDLE):
  - `busy` = 1 from E through edge E+IN_W+1.
  - SHIFT occupies edges E+1 … E+IN_W.
  - FINISH is registered at E+IN_W+1. `done` = 1 and the new `bcd_out` are visible after that edge, and `busy` = 0 at the same edge.
  - Latency start→done is IN_W+1 = 66 cycles.
- `done` and `start` in the same cycle: the FSM is in IDLE after FINISH, so `start` sampled on the cycle `done` is high is accepted. Back-to-back throughput is one conversion per 67 cycles.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Structure
- Shared package `bcd_pkg` holds:
  - `IN_W`/`DIGITS` defaults
  - the state enum (IDLE, SHIFT, FINISH)
  - counter width = clog2(IN_W+1)
- Sub-module `bcd_digit_adj`: 4-bit combinational "if ≥5 add 3". Instantiated DIGITS times via generate.
- Top `sum_bcd_converter`: FSM, counter, shift register, output register.

## Test plan
- Reset then idle:
  - Stimulus: reset, then hold `start`=0 for 100 cycles.
  - Required: `bcd_out`=0, `busy`=0, `done`=0 throughout.
- `bin_in`=1440 (184+1256), start pulse:
  - `done` exactly 66 cycles later.
  - `bcd_out`[15:0]=16'h1440, upper digits 0.
- `bin_in`=156722120 (156596564+125556):
  - `bcd_out` digits = 0…0156722120.
  - `busy` high for 66 cycles.
- Wide sums:
  - `bin_in`=18446744073709551615 (18446744073709551614+1) → digits 18446744073709551615.
  - `bin_in`=2^65−1 → 36893488147419103231.
- Ignored mid-conversion start:
  - Start with 21 (14+7); at cycle 10, pulse `start` with `bin_in`=999.
  - Single `done` at cycle 66, `bcd_out`=...0021.
  - A second `done` follows only if `start` is re-asserted afterward.
- Reset mid-conversion:
  - Start with 21 after a prior result of 1440; assert `rst` at cycle 30.
  - No `done`; `bcd_out`=0, `busy`=0.
  - A subsequent start with 14 yields ...0014 after 66 cycles.
